// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle multiply/divide unit with architectural HI/LO.
// Sits beside the ALU in the MIPS-32 execute stage and runs MULT, MULTU, DIV
// and DIVU one bit per cycle. MTHI and MTLO write HI/LO in a single cycle.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   srca       multiplicand / dividend / MTHI-MTLO source
//   srcb       multiplier / divisor
//   mdcontrol  000 nop, 001 mult, 010 multu, 011 div, 100 divu,
//              101 mthi, 110 mtlo, 111 nop
//   start      request, only honoured while busy is low
//   flush      abort the in-flight operation; also blocks a start in IDLE
//   busy       operation in progress (pipeline stall request)
//   done       one-cycle pulse after HI/LO were written by a mult/div
//   hi, lo     architectural HI/LO registers
module mdu_iterative #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic [2:0]      mdcontrol,
  input  logic            start,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FIX = 2'b10} state_t;

  state_t              state_r, state_next_s;
  logic [CW-1:0]       counter_r;
  logic [2*XLEN-1:0]   acc_r;
  logic [XLEN-1:0]     op_a_r, b_mag_r;
  logic                is_div_r, is_signed_r, neg_q_r, neg_r_r, div0_r;
  logic                busy_r, done_r;
  logic [XLEN-1:0]     hi_r, lo_r;

  logic                accept_s, load_hi_s, load_lo_s, commit_s;
  logic                start_signed_s, start_div_s;
  logic [XLEN-1:0]     start_a_mag_s, start_b_mag_s;
  logic [XLEN-1:0]     a_mag_s;
  logic [XLEN:0]       sum_s, shifted_s;
  logic [XLEN-1:0]     diff_s;
  logic                ge_s;
  logic [2*XLEN-1:0]   step_s, prod_s;
  logic [XLEN-1:0]     quo_s, rem_s, res_hi_s, res_lo_s;

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  assign start_signed_s = (mdcontrol == OP_MULT) || (mdcontrol == OP_DIV);
  assign start_div_s    = (mdcontrol == OP_DIV)  || (mdcontrol == OP_DIVU);
  assign start_a_mag_s  = (start_signed_s && srca[XLEN-1]) ? ({XLEN{1'b0}} - srca) : srca;
  assign start_b_mag_s  = (start_signed_s && srcb[XLEN-1]) ? ({XLEN{1'b0}} - srcb) : srcb;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= IDLE;
    else         state_r <= state_next_s;
  end

  // Next-state and control decode; flush outranks both start and commit.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    load_hi_s    = 1'b0;
    load_lo_s    = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (flush) begin
          state_next_s = IDLE;
        end else if (start) begin
          case (mdcontrol)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_next_s = RUN;
              accept_s     = 1'b1;
            end
            OP_MTHI: load_hi_s = 1'b1;
            OP_MTLO: load_lo_s = 1'b1;
            default: state_next_s = IDLE;
          endcase
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (flush)                        state_next_s = IDLE;
        else if (counter_r == {CW{1'b0}}) state_next_s = FIX;
        else                              state_next_s = RUN;
      end
      FIX: begin
        if (flush) begin
          state_next_s = IDLE;
        end else begin
          commit_s     = 1'b1;
          state_next_s = IDLE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide, plus sign fix-up.
  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    a_mag_s   = (is_signed_r && op_a_r[XLEN-1]) ? ({XLEN{1'b0}} - op_a_r) : op_a_r;
    sum_s     = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, a_mag_s} : {(XLEN+1){1'b0}});
    shifted_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    ge_s      = (shifted_s >= {1'b0, b_mag_r});
    // When the trial subtraction succeeds the true difference is below the divisor,
    // so the low XLEN bits carry it exactly.
    diff_s    = shifted_s[XLEN-1:0] - b_mag_r;
    if (is_div_r) begin
      if (ge_s) step_s = {diff_s, acc_r[XLEN-2:0], 1'b1};
      else      step_s = {shifted_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
    end else begin
      step_s = {sum_s, acc_r[XLEN-1:1]};
    end

    prod_s = neg_q_r ? ({(2*XLEN){1'b0}} - acc_r) : acc_r;
    quo_s  = neg_q_r ? ({XLEN{1'b0}} - acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
    rem_s  = neg_r_r ? ({XLEN{1'b0}} - acc_r[2*XLEN-1:XLEN]) : acc_r[2*XLEN-1:XLEN];
    if (is_div_r) begin
      if (div0_r) begin
        res_hi_s = op_a_r;
        res_lo_s = {XLEN{1'b1}};
      end else begin
        res_hi_s = rem_s;
        res_lo_s = quo_s;
      end
    end else begin
      res_hi_s = prod_s[2*XLEN-1:XLEN];
      res_lo_s = prod_s[XLEN-1:0];
    end
  end

  // Operand latch, iteration datapath, HI/LO and status registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      counter_r   <= {CW{1'b0}};
      acc_r       <= {(2*XLEN){1'b0}};
      op_a_r      <= {XLEN{1'b0}};
      b_mag_r     <= {XLEN{1'b0}};
      is_div_r    <= 1'b0;
      is_signed_r <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      div0_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      hi_r        <= {XLEN{1'b0}};
      lo_r        <= {XLEN{1'b0}};
    end else begin
      busy_r <= (state_next_s != IDLE);
      done_r <= commit_s;
      if (accept_s) begin
        counter_r   <= CW'(ITER - 1);
        acc_r       <= start_div_s ? {{XLEN{1'b0}}, start_a_mag_s} : {{XLEN{1'b0}}, start_b_mag_s};
        op_a_r      <= srca;
        b_mag_r     <= start_b_mag_s;
        is_div_r    <= start_div_s;
        is_signed_r <= start_signed_s;
        neg_q_r     <= start_signed_s && (srca[XLEN-1] ^ srcb[XLEN-1]);
        neg_r_r     <= start_signed_s && srca[XLEN-1];
        div0_r      <= (srcb == {XLEN{1'b0}});
      end else if (state_r == RUN) begin
        acc_r <= step_s;
        if (counter_r != {CW{1'b0}}) counter_r <= counter_r - {{(CW-1){1'b0}}, 1'b1};
      end
      if (load_hi_s) hi_r <= srca;
      if (load_lo_s) lo_r <= srca;
      if (commit_s) begin
        hi_r <= res_hi_s;
        lo_r <= res_lo_s;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: directed cases, flush/ignore/reset
// scenarios and randomized back-to-back operations against an arithmetic model.
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] srca = 32'd0, srcb = 32'd0;
  logic [2:0]  mdcontrol = 3'd0;
  logic        start = 1'b0, flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mdu_iterative #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .resetn(resetn), .srca(srca), .srcb(srcb),
    .mdcontrol(mdcontrol), .start(start), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural result {HI, LO} straight from MIPS arithmetic rules.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    int          sa, sb;
    longint      p;
    sa = a;
    sb = b;
    r  = 64'd0;
    case (op)
      3'b001: begin p = longint'(sa) * longint'(sb); r = p; end
      3'b010: r = {32'd0, a} * {32'd0, b};
      3'b011: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'd0, 32'h80000000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      3'b100: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else r = {a % b, a / b};
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // Issue one mult/div; returns in the done cycle so the next call is back-to-back.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp;
    int n, early;
    exp = model(op, a, b);
    @(negedge clk);
    srca = a; srcb = b; mdcontrol = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; srca = $urandom; srcb = $urandom;
    n = 0; early = 0;
    while (busy === 1'b1 && n < 40) begin
      if (done !== 1'b0) early++;
      n++;
      @(posedge clk); #1;
    end
    check({tag, " busy_cycles"}, 64'(n), 64'd33);
    check({tag, " done_early"}, 64'(early), 64'd0);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
    check({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
  endtask

  // Single-cycle MTHI/MTLO write while idle.
  task automatic do_mt(input logic [2:0] op, input logic [31:0] v, input string tag);
    @(negedge clk);
    srca = v; mdcontrol = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
  endtask

  initial begin
    int bad, n;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    // Reset state
    #12;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    @(negedge clk); resetn = 1'b1;

    // Directed arithmetic, issued back-to-back
    do_op(3'b001, 32'hFFFFFFFD, 32'd7, "mult_neg3x7");
    do_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    do_op(3'b011, 32'hFFFFFFF9, 32'd2, "div_m7_2");
    do_op(3'b100, 32'd100, 32'd7, "divu_100_7");
    do_op(3'b011, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    do_op(3'b100, 32'h00001234, 32'd0, "divu_zero");
    do_op(3'b011, 32'h00000010, 32'd0, "div_zero");
    do_op(3'b001, 32'h80000000, 32'h80000000, "mult_minmin");

    // Preload HI/LO
    do_mt(3'b101, 32'h55, "mthi");
    do_mt(3'b110, 32'h55, "mtlo");
    check("preload hi", 64'(hi), 64'h55);
    check("preload lo", 64'(lo), 64'h55);

    // Flush at cycle 10 of a mult
    @(negedge clk); srca = 32'd3; srcb = 32'd5; mdcontrol = 3'b001; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("flush quiet", 64'(bad), 64'd0);
    check("flush hi", 64'(hi), 64'h55);
    check("flush lo", 64'(lo), 64'h55);

    // Flush in IDLE suppresses a simultaneous start
    @(negedge clk); mdcontrol = 3'b001; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    check("idle flush busy", 64'(busy), 64'd0);

    // mtlo while busy is ignored
    @(negedge clk); srca = 32'd3; srcb = 32'd5; mdcontrol = 3'b001; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); srca = 32'hAA; mdcontrol = 3'b110; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("busy mtlo lo", 64'(lo), 64'h55);
    check("busy mtlo busy", 64'(busy), 64'd1);
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; @(posedge clk); #1; end
    check("busy mtlo done", 64'(done), 64'd1);
    check("busy mtlo hi", 64'(hi), 64'd0);
    check("busy mtlo res", 64'(lo), 64'd15);

    // Reset at cycle 20 of a div
    @(negedge clk); srca = 32'd1000; srcb = 32'd7; mdcontrol = 3'b011; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk); resetn = 1'b0;
    #1;
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst lo", 64'(lo), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    @(negedge clk); resetn = 1'b1;
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("midrst idle", 64'(bad), 64'd0);
    check("midrst hi after", 64'(hi), 64'd0);

    // Randomized back-to-back operations
    for (int i = 0; i < 20; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
      do_op(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
